// File: rtl/exp_add_pkg.sv
// Shared FPU exponent package: widths, bias, saturation limits and the
// exponent/sum/result types used by the exponent adder and its saturator.
package exp_add_pkg;

  localparam int EXP_W    = 8;
  localparam int EXP_BIAS = 127;

  // Biased 8-bit exponent.
  typedef logic [EXP_W-1:0] exp_t;

  // 10-bit signed intermediate sum: covers -127..383 with no wrap.
  typedef logic signed [EXP_W+1:0] sum_t;

  localparam exp_t EXP_MAX  = 8'hFF;
  localparam exp_t EXP_ZERO = 8'h00;

  // Saturated exponent plus overflow (oom) and underflow (vec) flags.
  typedef struct packed {
    exp_t out;
    logic oom;
    logic vec;
  } exp_res_t;

endpackage

// File: rtl/exp_add_sat.sv
// Saturation and flag logic for the biased-exponent adder. Purely
// combinational: special operands first, then overflow, then underflow.
module exp_add_sat
  import exp_add_pkg::*;
(
  input  sum_t     s,
  input  logic     spec_inf,
  input  logic     spec_zero,
  output exp_res_t res
);

  localparam sum_t SAT_HI = 10'sd255;
  localparam sum_t SAT_LO = 10'sd0;

  // Priority-ordered saturation; oom and vec are mutually exclusive by construction.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    res.out = EXP_ZERO;
    res.oom = 1'b0;
    res.vec = 1'b0;
    if (spec_inf) begin
      res.out = EXP_MAX;
      res.oom = 1'b1;
    end else if (spec_zero) begin
      res.vec = 1'b1;
    end else if (s >= SAT_HI) begin
      res.out = EXP_MAX;
      res.oom = 1'b1;
    end else if (s <= SAT_LO) begin
      res.vec = 1'b1;
    end else begin
      res.out = s[EXP_W-1:0];
    end
  end

endmodule

// File: rtl/exp_add.sv
// Biased-exponent adder for the FPU multiplier path: out = sat(in1 + in2 - BIAS)
// with overflow (oom) and underflow (vec) flags, registered.
// Build option: define EXP_ADD_PIPE2_EN to register the raw sum and the
// special-operand bits first, giving 2-cycle latency; default is 1 cycle.
module exp_add
  import exp_add_pkg::*;
#(
  parameter int BIAS = EXP_BIAS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [EXP_W-1:0] in1,
  input  logic [EXP_W-1:0] in2,
  output logic [EXP_W-1:0] out,
  output logic             oom,
  output logic             vec
);

  sum_t     s_d;
  logic     inf_d;
  logic     zero_d;
  exp_res_t res_d;
  exp_res_t res_q;

  // Wide signed sum and special-operand detection from the raw inputs.
  always_comb begin
    s_d    = sum_t'({2'b00, in1}) + sum_t'({2'b00, in2}) - sum_t'(BIAS);
    inf_d  = (in1 == EXP_MAX)  || (in2 == EXP_MAX);
    zero_d = (in1 == EXP_ZERO) || (in2 == EXP_ZERO);
  end

`ifdef EXP_ADD_PIPE2_EN
  sum_t s_q;
  logic inf_q;
  logic zero_q;

  // First stage: hold the raw sum and special bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      inf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      inf_q  <= inf_d;
      zero_q <= zero_d;
    end
  end

  exp_add_sat u_sat (
    .s         (s_q),
    .spec_inf  (inf_q),
    .spec_zero (zero_q),
    .res       (res_d)
  );
`else
  exp_add_sat u_sat (
    .s         (s_d),
    .spec_inf  (inf_d),
    .spec_zero (zero_d),
    .res       (res_d)
  );
`endif

  // Output stage: saturated exponent and flags; reset clears everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      res_q <= res_d;
    end
  end

  assign out = res_q.out;
  assign oom = res_q.oom;
  assign vec = res_q.vec;

endmodule

// File: tb/tb_exp_add.sv
// Scoreboard bench for exp_add: the driver pushes the expected response with
// the cycle it is due; a monitor pops and compares after every rising edge.
module tb_exp_add;

`ifdef EXP_ADD_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [7:0] out;
  logic       oom;
  logic       vec;

  exp_add dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in1   (in1),
    .in2   (in2),
    .out   (out),
    .oom   (oom),
    .vec   (vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] out;
    logic       oom;
    logic       vec;
    string      name;
  } exp_item_t;

  exp_item_t sb_q[$];
  int        cyc    = 0;
  int        checks = 0;
  int        errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference for the sweep.
  function automatic exp_item_t model(input int a, input int b);
    exp_item_t it;
    int s;
    s = a + b - 127;
    it.out = 8'h00; it.oom = 1'b0; it.vec = 1'b0;
    if (a == 255 || b == 255) begin it.out = 8'hFF; it.oom = 1'b1; end
    else if (a == 0 || b == 0) it.vec = 1'b1;
    else if (s >= 255) begin it.out = 8'hFF; it.oom = 1'b1; end
    else if (s <= 0) it.vec = 1'b1;
    else it.out = 8'(s);
    return it;
  endfunction

  // Drive one vector before the next rising edge and queue its expectation.
  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] e_out, input logic e_oom, input logic e_vec,
                       input string name);
    exp_item_t it;
    @(negedge clk);
    in1 = a;
    in2 = b;
    it.due = cyc + LAT;
    it.out = e_out; it.oom = e_oom; it.vec = e_vec;
    it.name = name;
    sb_q.push_back(it);
  endtask

  // Monitor: compare every due expectation just after the edge that produces it.
  initial begin
    exp_item_t it;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        it = sb_q.pop_front();
        if (it.due < cyc) begin
          check({it.name, "_missed"}, 32'(it.due), 32'(cyc));
        end else begin
          check(it.name, {out, oom, vec}, {it.out, it.oom, it.vec});
          check({it.name, "_excl"}, 32'(oom & vec), 32'd0);
        end
      end
    end
  end

  initial begin
    exp_item_t m;
    logic [7:0] v;
    int wait_cyc;

    rst_n = 1'b0;
    in1   = 8'd0;
    in2   = 8'd0;
    #3;
    check("reset_state", {out, oom, vec}, {8'h00, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    drive(8'd127, 8'd127, 8'd127, 1'b0, 1'b0, "mid_127_127");
    drive(8'd128, 8'd1,   8'd2,   1'b0, 1'b0, "small_128_1");
    drive(8'd254, 8'd127, 8'd254, 1'b0, 1'b0, "ovf_edge_254");
    drive(8'd254, 8'd128, 8'hFF,  1'b1, 1'b0, "ovf_255");
    drive(8'd200, 8'd200, 8'hFF,  1'b1, 1'b0, "ovf_200_200");
    drive(8'd64,  8'd64,  8'd1,   1'b0, 1'b0, "udf_edge_1");
    drive(8'd64,  8'd63,  8'd0,   1'b0, 1'b1, "udf_0");
    drive(8'd50,  8'd60,  8'd0,   1'b0, 1'b1, "udf_neg");
    drive(8'd0,   8'd200, 8'd0,   1'b0, 1'b1, "spec_zero");
    drive(8'd255, 8'd0,   8'hFF,  1'b1, 1'b0, "spec_inf_wins");

    // Sweep in1 = in2 from 1 upward, wrapping 255 -> 0, with a reset mid-stream.
    v = 8'd1;
    for (int i = 0; i < 300; i++) begin
      if (i == 220) begin
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("async_reset", {out, oom, vec}, {8'h00, 1'b0, 1'b0});
        @(negedge clk);
        check("reset_hold", {out, oom, vec}, {8'h00, 1'b0, 1'b0});
        rst_n = 1'b1;
      end
      m = model(int'(v), int'(v));
      drive(v, v, m.out, m.oom, m.vec, $sformatf("sweep_%0d", v));
      v = v + 8'd1;
    end

    // Let the pipeline drain, bounded.
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    check("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
